// File: rtl/sirius_mem_pkg.sv
// Shared types for the memory-stage data access controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sirius_mem_pkg;

  // Access sequencing states of the data-bus request controller.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no access in flight
    REQ  = 2'd1,  // request presented, waiting for address acceptance
    WAIT = 2'd2,  // request accepted, waiting for completion
    DONE = 2'd3   // complete, waiting for the stage to advance
  } dmem_state_t;

  localparam logic [3:0] DMEM_STRB_NONE = 4'b0000;

endpackage

// File: rtl/dmem_wbuf.sv
// Posted-write tracker: remembers a store accepted but not yet completed.
// Latency: wr_pending sets the cycle after acceptance, clears the cycle after bus_data_ok.
// Backpressure: holds off the next bus request while a posted write is outstanding.
//
// Ports: set (posted store accepted), data_ok (bus completion), req_in (controller
// wants to request), req_out (request actually presented on the bus).
// Used only when DMEM_POSTED_WRITE_EN is defined.
module dmem_wbuf (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic data_ok,
  input  logic req_in,
  output logic req_out
);

  logic wr_pending;

  // A new posted store can only be accepted when no write is pending, so set
  // and the completion of an older write never belong to the same request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_pending <= 1'b0;
    end else if (set) begin
      wr_pending <= 1'b1;
    end else if (data_ok) begin
      wr_pending <= 1'b0;
    end
  end

  // Keeping the request low while pending guarantees bus_data_ok is clearly
  // attributable to the posted write and never to the next access.
  assign req_out = req_in & ~wr_pending;

endmodule

// File: rtl/dmem_req_ctrl.sv
// Sequences the memory stage's single-cycle data access onto a req/addr_ok/data_ok bus.
// Latency: min 3 cycles from mem_en to DONE (addr_ok in c1, data_ok in c2, data in c3).
// Backpressure: stall held through REQ/WAIT; DONE held under pipe_stall; bus_req never withdrawn.
//
// Ports: mem_* access from the stage, mem_rdata registered load data (valid in DONE),
// pipe_stall/flush from the pipeline, stall back to the stage, bus_* request channel
// (req/wr/wstrb/addr/wdata out, addr_ok/data_ok/rdata in). clk, async active-low rst.
// Option: DMEM_POSTED_WRITE_EN lets stores finish at address acceptance (posted).
module dmem_req_ctrl
  import sirius_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_wr,
  output logic [3:0]        bus_wstrb,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata
);

  typedef struct packed {
    logic              wr;
    logic [3:0]        strb;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

`ifdef DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  dmem_state_t       state_q, state_d;
  req_t              req_q, req_d;
  logic              cancel_q, cancel_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              req_gated;
  logic              accepted;
  logic              posted_set;

`ifdef DMEM_POSTED_WRITE_EN
  dmem_wbuf u_wbuf (
    .clk     (clk),
    .rst     (rst),
    .set     (posted_set),
    .data_ok (bus_data_ok),
    .req_in  (state_q == REQ),
    .req_out (req_gated)
  );
`else
  assign req_gated = (state_q == REQ);
`endif

  // addr_ok only counts when a request is actually visible on the bus.
  assign accepted   = (state_q == REQ) & req_gated & bus_addr_ok;
  // A live store may retire at acceptance; a flushed one still drains via WAIT.
  assign posted_set = POSTED & accepted & req_q.wr & ~cancel_q & ~flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      cancel_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      cancel_q <= cancel_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    cancel_d = cancel_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (mem_en && !flush) begin
          state_d     = REQ;
          cancel_d    = 1'b0;
          req_d.wr    = (mem_wen != DMEM_STRB_NONE);
          req_d.strb  = mem_wen;
          req_d.addr  = mem_addr;
          req_d.wdata = mem_wdata;
        end
      end
      REQ: begin
        // The request stays up even when flushed; the bus owns it once presented.
        if (flush) cancel_d = 1'b1;
        if (accepted) state_d = posted_set ? DONE : WAIT;
      end
      WAIT: begin
        if (bus_data_ok) begin
          if (cancel_q || flush) begin
            state_d  = IDLE;
            cancel_d = 1'b0;
          end else begin
            state_d = DONE;
            if (!req_q.wr) rdata_d = bus_rdata;
          end
        end else if (flush) begin
          cancel_d = 1'b1;
        end
      end
      DONE: begin
        if (!pipe_stall || flush) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // rst gates stall so the stage is free while the controller is held in reset.
  assign stall     = rst & (((state_q == IDLE) & mem_en & ~flush) |
                            (state_q == REQ) | (state_q == WAIT));
  assign bus_req   = req_gated;
  assign bus_wr    = req_q.wr;
  assign bus_wstrb = req_q.strb;
  assign bus_addr  = req_q.addr;
  assign bus_wdata = req_q.wdata;
  assign mem_rdata = rdata_q;

endmodule
